md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide unit of the EX stage. Consumes the two register operands read from the GRF
//  (rs_val, rt_val) and owns the HI/LO registers. Its HI/LO values return to the GRF write port
//  through the MFHI/MFLO writeback path. Multi-cycle: asserts busy so hazard control stalls
//  later MD instructions until the result is committed.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy is high after a MULT/MULTU start (>=1)
//  DIV_CYCLES   10  cycles busy is high after a DIV/DIVU start (>=1)
//  CNT_W        4   counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   synchronous, active-high
//  start    in   1   issue md_op this cycle (single-cycle pulse from EX)
//  md_op    in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NONE)
//  rs_val   in   32  operand A / dividend / MTHI-MTLO source (forwarded GRF RD1)
//  rt_val   in   32  operand B / divisor (forwarded GRF RD2)
//  busy     out  1   long operation in flight
//  hi       out  32  architectural HI
//  lo       out  32  architectural LO
// BEHAVIOUR
//  - Reset: busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset mid-operation aborts.
//    The aborted result is never committed.
//  - Accept: start=1 with busy=0 only. start while busy=1 is ignored; the controller stalls
//    on (start|busy) for MD ops.
//  - MULT/MULTU/DIV/DIVU accept at edge T: operands are captured and the result is computed
//    into a pending {p_hi,p_lo}. busy=1 from T. The counter loads N-1.
//    N = MULT_CYCLES or DIV_CYCLES.
//  - Counter decrements each edge while busy. At the edge where counter==0: hi<=p_hi,
//    lo<=p_lo, busy<=0. busy is therefore high for exactly N cycles.
//  - hi/lo hold their old values while busy. New values are visible the cycle busy falls.
//  - MTHI/MTLO: hi<=rs_val or lo<=rs_val at edge T. busy stays 0. Latency is 1 cycle.
//  - MULT: signed 32x32->64 result, {hi,lo}. MULTU: unsigned 32x32->64 result.
//  - DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
//    DIVU: unsigned quotient and remainder.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
//  - Divisor 0 (DIV/DIVU): busy behaves normally and hi/lo are left unchanged at commit.
//  - md_op NONE/reserved with start=1: no state change.
//  - start=1 on the same edge that busy falls: start is ignored (busy was still 1).
//    The op is reissued the next cycle.
// STRUCTURE
//  - Package md_pkg: md_op encodings (MD_NONE..MD_MTLO) and default cycle-count constants.
//    Shared with the controller and hazard unit.
//  - Sub-module md_calc: purely combinational 64-bit mult/div datapath.
//    Inputs: op, a, b. Outputs: res_hi, res_lo, div0.
//  - The top level holds the counter, busy flag, pending regs and HI/LO.
//    Busy is a 2-state FSM: IDLE -> RUN on accepted long op; RUN -> IDLE when counter==0.
// TESTING
//  - MULT 0xFFFFFFFE x 0x00000003 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
//  - DIV 0xFFFFFFF9(-7) / 2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIVU 7/2 -> lo=3, hi=1.
//  - MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> busy never rises;
//    hi and lo are updated on the next edge each.
//  - DIV x/0 after MTHI 0xAA, MTLO 0xBB -> busy 10 cycles; hi=0xAA, lo=0xBB unchanged.
//  - Reset on cycle 3 of a DIV; a MULT start while busy; MULT started on the busy-fall edge ->
//    reset: busy=0, hi=lo=0, and no later commit occurs.
//    MULT while busy: ignored. MULT on busy-fall edge: ignored; reissued, it completes normally.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default timing.
package md_pkg;

  localparam int unsigned MD_XLEN        = 32;
  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;
  localparam int unsigned MD_CNT_W       = 4;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply / 32/32 divide datapath producing a {hi,lo} result.
module md_calc
  import md_pkg::*;
(
  input  md_op_e             op,
  input  logic [MD_XLEN-1:0] a,
  input  logic [MD_XLEN-1:0] b,
  output logic [MD_XLEN-1:0] res_hi,
  output logic [MD_XLEN-1:0] res_lo,
  output logic               div0
);

  logic signed [2*MD_XLEN-1:0] prod_s;
  logic        [2*MD_XLEN-1:0] prod_u;
  logic        [MD_XLEN-1:0]   b_safe;
  logic signed [MD_XLEN-1:0]   q_s;
  logic signed [MD_XLEN-1:0]   r_s;
  logic        [MD_XLEN-1:0]   q_u;
  logic        [MD_XLEN-1:0]   r_u;
  logic                        ovf;

  assign prod_s = $signed({{MD_XLEN{a[MD_XLEN-1]}}, a}) * $signed({{MD_XLEN{b[MD_XLEN-1]}}, b});
  assign prod_u = {{MD_XLEN{1'b0}}, a} * {{MD_XLEN{1'b0}}, b};

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign div0   = (b == '0);
  assign b_safe = div0 ? MD_XLEN'(1) : b;
  assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign q_s = $signed(a) / $signed(b_safe);
  assign r_s = $signed(a) % $signed(b_safe);
  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (ovf) begin
          res_hi = '0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      MD_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs long ops for a fixed cycle count, then commits.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int unsigned CNT_W       = MD_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          md_op,
  input  logic [MD_XLEN-1:0]  rs_val,
  input  logic [MD_XLEN-1:0]  rt_val,
  output logic                busy,
  output logic [MD_XLEN-1:0]  hi,
  output logic [MD_XLEN-1:0]  lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [MD_XLEN-1:0] p_hi;
  logic [MD_XLEN-1:0] p_lo;
  logic               p_wr;
  md_op_e             op;
  logic [MD_XLEN-1:0] res_hi;
  logic [MD_XLEN-1:0] res_lo;
  logic               div0;

  assign op = md_op_e'(md_op);

  md_calc u_calc (
    .op     (op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  // Result is computed at accept and parked in p_hi/p_lo until the counter expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_wr  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                state <= ST_RUN;
                busy  <= 1'b1;
                cnt   <= MULT_LOAD;
                p_hi  <= res_hi;
                p_lo  <= res_lo;
                p_wr  <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                state <= ST_RUN;
                busy  <= 1'b1;
                cnt   <= DIV_LOAD;
                p_hi  <= res_hi;
                p_lo  <= res_lo;
                p_wr  <= ~div0;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            p_wr  <= 1'b0;
            if (p_wr) begin
              hi <= p_hi;
              lo <= p_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes model results, monitor checks them at commit.
`timescale 1ns/1ps
module tb_md_unit;
  import md_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_long;
    int          len;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Architectural reference: HI/LO after the op, from plain 64-bit integer arithmetic.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ch, input logic [31:0] cl,
                                 output logic [31:0] nh, output logic [31:0] nl);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = ch;
    nl = cl;
    case (op)
      3'd1: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; end
      3'd2: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; end
      3'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; nh = sr[31:0]; nl = sq[31:0]; end
      3'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; nh = ur[31:0]; nl = uq[31:0]; end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] nh, nl;
    wait_idle();
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    ref_md(op, a, b, m_hi, m_lo, nh, nl);
    e.is_long = (op >= 3'd1 && op <= 3'd4);
    e.len     = (op <= 3'd2) ? MC : DC;
    e.hold_hi = m_hi;
    e.hold_lo = m_lo;
    e.hi      = nh;
    e.lo      = nl;
    sbq.push_back(e);
    m_hi = nh;
    m_lo = nl;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
  endtask

  // Drive a start that must be ignored; nothing is expected from it.
  task automatic poke(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
  endtask

  // Monitor: hold check while busy, commit check on busy fall, 1-cycle check for short ops.
  logic prev_busy = 1'b0;
  int   blen = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      prev_busy = 1'b0;
      blen      = 0;
    end else begin
      if (busy) begin
        blen++;
        if (sbq.size() > 0 && sbq[0].is_long) begin
          chk("hold_hi", 64'(hi), 64'(sbq[0].hold_hi));
          chk("hold_lo", 64'(lo), 64'(sbq[0].hold_lo));
        end else begin
          fail_now("unexpected_busy");
        end
      end else if (prev_busy) begin
        if (sbq.size() > 0 && sbq[0].is_long) begin
          e = sbq.pop_front();
          chk("commit_hi", 64'(hi), 64'(e.hi));
          chk("commit_lo", 64'(lo), 64'(e.lo));
          chk("busy_len", 64'(blen), 64'(e.len));
        end else begin
          fail_now("unexpected_commit");
        end
        blen = 0;
      end else if (sbq.size() > 0 && !sbq[0].is_long) begin
        e = sbq.pop_front();
        chk("short_hi", 64'(hi), 64'(e.hi));
        chk("short_lo", 64'(lo), 64'(e.lo));
      end
      prev_busy = busy;
    end
  end

  function automatic logic [31:0] pick_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'd0;
      3: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          t;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(3'd4, 32'd7, 32'd2);
    issue(3'd5, 32'h1234_5678, 32'd0);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd5, 32'h0000_00AA, 32'd0);
    issue(3'd6, 32'h0000_00BB, 32'd0);
    issue(3'd3, 32'h0000_1234, 32'd0);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    issue(3'd0, 32'h5555_5555, 32'd1);
    issue(3'd7, 32'h6666_6666, 32'd1);

    // MULT while busy is ignored.
    issue(3'd1, 32'd3, 32'd4);
    poke(3'd1, 32'd100, 32'd200);
    poke(3'd5, 32'hCAFE_0000, 32'd0);

    // MULT on the busy-fall edge is ignored, then reissued.
    issue(3'd4, 32'd1000, 32'd7);
    repeat (DC - 1) @(negedge clk);
    poke(3'd1, 32'd9, 32'd9);
    issue(3'd1, 32'd9, 32'd9);

    // Reset mid-DIV aborts the op; nothing commits afterwards.
    issue(3'd3, 32'd77, 32'd5);
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    repeat (15) @(negedge clk);
    issue(3'd0, 32'd0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_val();
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
      issue(rop, ra, rb);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    t = 0;
    while (sbq.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) fail_now("drain_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
